// File: rtl/fir_decim_fifo_if.sv
// Handshake bundle between the FIR output stage, the decimating FIFO and its consumer.
interface fir_decim_fifo_if #(
  parameter int unsigned data_width = 16,
  parameter int unsigned depth      = 8
);
  localparam int unsigned cnt_w = $clog2(depth) + 1;

  logic                  valid_in;
  logic [data_width-1:0] data_in;
  logic                  out_ready;
  logic                  clear_ovf;
  logic                  out_valid;
  logic [data_width-1:0] data_out;
  logic [cnt_w-1:0]      count;
  logic                  overflow;

  modport master (
    output valid_in, data_in, out_ready, clear_ovf,
    input  out_valid, data_out, count, overflow
  );

  modport slave (
    input  valid_in, data_in, out_ready, clear_ovf,
    output out_valid, data_out, count, overflow
  );
endinterface

// File: rtl/fir_decim_fifo.sv
// Decimates an unthrottled FIR sample stream and buffers kept samples in a
// first-word-fall-through FIFO with a sticky overflow flag.
module fir_decim_fifo #(
  parameter int unsigned data_width = 16,
  parameter int unsigned decim      = 2,
  parameter int unsigned depth      = 8
) (
  input logic            clk,
  input logic            rst,
  fir_decim_fifo_if.slave bus
);
  localparam int unsigned aw    = $clog2(depth);
  localparam int unsigned cnt_w = aw + 1;
  localparam int unsigned pw    = (decim > 1) ? $clog2(decim) : 1;

  logic [data_width-1:0] mem [depth];
  logic [pw-1:0]         phase_q, phase_d;
  logic [aw-1:0]         rd_ptr_q, rd_ptr_d;
  logic [aw-1:0]         wr_ptr_q, wr_ptr_d;
  logic [cnt_w-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;

  logic keep, full, pop, push, drop, out_valid;

  assign out_valid = (count_q != '0);
  assign full      = (count_q == cnt_w'(depth));
  assign keep      = bus.valid_in && (phase_q == '0);
  assign pop       = out_valid && bus.out_ready;
  // A full FIFO still accepts a kept sample when the head leaves on the same edge.
  assign push      = keep && (!full || pop);
  assign drop      = keep && full && !pop;

  always_comb begin
    phase_d    = phase_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (bus.valid_in) begin
      if (phase_q == pw'(decim - 1)) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    // Set wins over clear so a drop is never lost.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (bus.clear_ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr_q] <= bus.data_in;
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.data_out  = out_valid ? mem[rd_ptr_q] : '0;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: doc/fir_decim_fifo.md
# fir_decim_fifo

Downstream consumer of the FIR filter output stage. Takes the filter's Q1.15 sample stream, which has a valid strobe and no backpressure. Decimates it by a fixed integer factor and buffers the kept samples in a small FIFO. Presents them to the next stage over a valid/ready handshake. Samples that arrive while the FIFO is full are dropped and flagged with a sticky overflow bit.

## Interface
- data_width, default 16: sample width, signed Q1.15.
- decim, default 2: decimation factor, integer ≥ 1 (1 = pass every sample).
- depth, default 8: FIFO entries, power of 2, ≥ 2.

- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  reset, synchronous and active-high.
- valid_in  input  1  data_in holds a new filter sample this cycle.
- data_in  input  data_width  signed Q1.15 sample from the FIR output stage.
- out_ready  input  1  downstream accepts data_out this cycle.
- out_valid  output  1  FIFO non-empty; data_out is valid.
- data_out  output  data_width  signed head-of-FIFO sample; all zeros when out_valid = 0.
- count  output  $clog2(depth)+1  current FIFO occupancy, 0..depth.
- overflow  output  1  sticky, set when a kept sample was dropped.
- clear_ovf  input  1  clears overflow.

## Operation
- **Phase counter:** range 0..decim-1.
  - Advances by 1 on every cycle with valid_in = 1, and wraps to 0 after decim-1.
  - It does not advance on cycles without valid_in. Gaps in valid_in do not affect decimation.
  - It advances even when the sample is dropped.
- **Kept sample:** valid_in = 1 and phase = 0. With decim = 2, samples 0, 2, 4, … of the valid stream are kept. No averaging; the FIR stage already did the filtering.
- **Push:** a kept sample is written at the tail when count < depth, or when count = depth and a pop occurs in the same cycle.
- **Drop:** a kept sample with count = depth and no pop is discarded. overflow is set to 1 on that edge, and FIFO contents are unchanged.
- **Pop:** out_valid = 1 and out_ready = 1. The head advances on that edge.
- **count update:**
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push+pop, and unchanged on neither.
- **Pointers:** read and write pointers are $clog2(depth) bits and wrap naturally modulo depth.
- **FIFO style:** first-word-fall-through. out_valid = (count != 0), and data_out = mem[rd_ptr] when out_valid = 1, otherwise 0.
- **Push to an empty FIFO with simultaneous pop:** impossible, because out_valid = 0 when empty. The push is simply taken.
- **overflow:**
  - Cleared by clear_ovf = 1.
  - If a drop and clear_ovf occur in the same cycle, set wins and overflow = 1.
- **Data handling:** samples pass bit-exact. No width change, no rounding.
- **rst (sampled at clk edge):** zeroes phase, rd_ptr, wr_ptr, count and overflow.
  - Memory contents need no reset.
  - A reset in the middle of operation discards buffered samples. The first valid_in after reset is a kept sample.
  - If valid_in is high during the reset cycle, it is ignored.

## Timing
- **Values after reset:** out_valid = 0, data_out = 0, count = 0, overflow = 0.
- **Latency:** a kept sample with valid_in high in cycle N, into an empty FIFO, gives out_valid = 1 and data_out = that sample in cycle N+1.
- **Throughput:** one push and one pop per cycle. Sustained input at 1 sample/cycle with decim ≥ 1 and out_ready held high never overflows.
- **Output stability:** data_out and out_valid are stable while out_ready = 0. After a pop, data_out shows the next entry on the following cycle.
- **Output registering:** all outputs are derived from registers or memory read with no combinational path from valid_in or data_in. out_ready affects state only at the next edge.
- overflow rises the cycle after the dropping edge.

## Test plan
1. **Single sample:** rst, then valid_in = 1 with data_in = 0x1234 for one cycle, out_ready = 0 → next cycle out_valid = 1, data_out = 0x1234, count = 1. Then out_ready = 1 for one cycle → out_valid = 0, data_out = 0, count = 0.
2. **Decimation with gaps:** valid_in on samples 1..6 with one idle cycle between each, out_ready = 0 → FIFO holds 1, 3, 5 and count = 3. Draining gives 1, 3, 5 in order.
3. **Overflow:** out_ready = 0, 20 back-to-back samples 0..19 →
   - FIFO holds 0, 2, …, 14 and count = 8.
   - Samples 16 and 18 are dropped.
   - overflow = 1 from the cycle after sample 16.
   - Draining returns 0..14 in order with no corruption.
4. **Full with simultaneous push/pop:** FIFO full, kept sample 0x7FFF arrives with out_ready = 1 in the same cycle → count stays 8, overflow stays 0, and 0x7FFF is the last value drained.
5. **Clear versus set:**
   - clear_ovf = 1 in the same cycle as a drop → overflow = 1.
   - clear_ovf = 1 alone on the next cycle → overflow = 0 the cycle after.
6. **Reset mid-operation:** count = 5, overflow = 1, phase = 1, then assert rst for one cycle with valid_in = 1 →
   - out_valid = 0, count = 0, overflow = 0.
   - The next valid sample 0x8000 is kept and appears on data_out one cycle later.
